// File: rtl/tone_pkg.sv
// Shared types for the tone contour classifier: FSM states, per-step codes,
// tone classes and the contour-to-tone classification rule.
package tone_pkg;

    // Longest contour the classifier supports (8 frames -> 7 steps).
    localparam int MAX_STEPS = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMPARE = 2'd2,
        ST_REPORT  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        STEP_FLAT = 2'b00,
        STEP_RISE = 2'b01,
        STEP_FALL = 2'b11
    } step_t;

    typedef enum logic [2:0] {
        TONE_NONE    = 3'b000,
        TONE_LEVEL   = 3'b001,
        TONE_RISING  = 3'b010,
        TONE_DIPPING = 3'b011,
        TONE_FALLING = 3'b100
    } tone_t;

    // Step k lives in codes[2k+1:2k] (k from 0); only the first n_steps count.
    // A fall seen before any later rise marks the contour as dipping.
    function automatic tone_t classify(input logic [2*MAX_STEPS-1:0] codes,
                                       input int n_steps);
        logic  any_rise;
        logic  any_fall;
        logic  dip;
        tone_t tone;
        any_rise = 1'b0;
        any_fall = 1'b0;
        dip      = 1'b0;
        for (int i = 0; i < MAX_STEPS; i++) begin
            if (i < n_steps) begin
                if (codes[2*i +: 2] == STEP_RISE) begin
                    any_rise = 1'b1;
                    if (any_fall) dip = 1'b1;
                end else if (codes[2*i +: 2] == STEP_FALL) begin
                    any_fall = 1'b1;
                end
            end
        end
        if (!any_rise && !any_fall) tone = TONE_LEVEL;
        else if (!any_fall)         tone = TONE_RISING;
        else if (dip)               tone = TONE_DIPPING;
        else if (!any_rise)         tone = TONE_FALLING;
        else                        tone = TONE_NONE;
        return tone;
    endfunction

endpackage

// File: rtl/tone_step_compare.sv
// Classifies one pitch step (prev -> curr) as flat, rising or falling.
// The percent threshold is tested by cross-multiplication, so no divider.
module tone_step_compare
    import tone_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int THRESH_PCT = 20
) (
    input  logic [DATA_WIDTH-1:0] prev,
    input  logic [DATA_WIDTH-1:0] curr,
    output step_t                 code
);

    localparam int PW = DATA_WIDTH + 8;
    localparam logic [PW-1:0] PCT_SCALE = PW'(100);
    localparam logic [PW-1:0] THRESH    = PW'(THRESH_PCT);

    logic signed [DATA_WIDTH:0] delta;
    logic signed [DATA_WIDTH:0] neg_delta;
    logic [DATA_WIDTH-1:0]      mag;
    logic [PW-1:0]              scaled_delta;
    logic [PW-1:0]              scaled_limit;

    // Signed delta, magnitude, and |delta|*100 >= THRESH_PCT*prev test.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        code         = STEP_FLAT;
        delta        = $signed({1'b0, curr}) - $signed({1'b0, prev});
        neg_delta    = -delta;
        mag          = delta[DATA_WIDTH] ? neg_delta[DATA_WIDTH-1:0] : delta[DATA_WIDTH-1:0];
        scaled_delta = {8'd0, mag} * PCT_SCALE;
        scaled_limit = {8'd0, prev} * THRESH;
        // A zero delta is always flat; prev == 0 with curr > 0 passes the test as a rise.
        if (delta != '0 && scaled_delta >= scaled_limit) begin
            code = delta[DATA_WIDTH] ? STEP_FALL : STEP_RISE;
        end
    end

endmodule

// File: rtl/tone_contour_classifier.sv
// Captures NUM_FRAMES pitch values, grades each consecutive step one per
// cycle, then reports the step contour and overall tone class.
module tone_contour_classifier
    import tone_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_FRAMES     = 4,
    parameter int THRESH_PCT     = 20,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        start_in,
    input  logic                        frame_valid_in,
    input  logic [DATA_WIDTH-1:0]       frame_data_in,
    output logic                        ready_out,
    output logic                        valid_out,
    output logic [2*(NUM_FRAMES-1)-1:0] contour_out,
    output logic [2:0]                  tone_out,
    output logic                        error_out
);

    localparam int STEPS  = NUM_FRAMES - 1;
    localparam int ADDR_W = $clog2(NUM_FRAMES);
    localparam int IDX_W  = ADDR_W + 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0]  IDX_FULL  = IDX_W'(NUM_FRAMES);
    localparam logic [ADDR_W-1:0] LAST_PREV = ADDR_W'(STEPS - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   frames [NUM_FRAMES];
    logic [IDX_W-1:0]        frame_idx;
    logic [ADDR_W-1:0]       cmp_idx;      // index of the earlier frame of the step being graded
    logic [TO_W-1:0]         timeout_cnt;
    logic [2*STEPS-1:0]      contour_acc;
    logic [2*STEPS-1:0]      contour_next;
    step_t                   step_code;
    logic                    capture_full;
    logic                    frame_take;
    logic                    timeout_hit;
    logic                    last_step;

    assign capture_full = (frame_idx == IDX_FULL);
    assign frame_take   = (state == ST_CAPTURE) && frame_valid_in && !capture_full;
    assign timeout_hit  = (state == ST_CAPTURE) && !capture_full && !frame_valid_in
                          && (timeout_cnt == TO_LAST);
    assign last_step    = (cmp_idx == LAST_PREV);
    assign ready_out    = (state == ST_IDLE);
    assign valid_out    = (state == ST_REPORT);

    tone_step_compare #(
        .DATA_WIDTH (DATA_WIDTH),
        .THRESH_PCT (THRESH_PCT)
    ) u_step_compare (
        .prev (frames[cmp_idx]),
        .curr (frames[cmp_idx + 1'b1]),
        .code (step_code)
    );

    // Merge the current step code into the contour being built.
    always_comb begin
        contour_next = contour_acc;
        contour_next[{cmp_idx, 1'b0} +: 2] = step_code;
    end

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_in) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; a full buffer waits one cycle in CAPTURE before grading starts.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start_in) state_next = ST_CAPTURE;
            ST_CAPTURE: begin
                if (capture_full)     state_next = ST_COMPARE;
                else if (timeout_hit) state_next = ST_IDLE;
            end
            ST_COMPARE: if (last_step) state_next = ST_REPORT;
            ST_REPORT:  state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Frame buffer write port.
    always_ff @(posedge clk_in) begin
        // NOTE: the frame buffer is not reset; frame_idx gates every read of it, so stale data is never used.
        if (frame_take) frames[frame_idx[ADDR_W-1:0]] <= frame_data_in;
    end

    // Counters, contour accumulation, result registers and the timeout strobe.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            frame_idx   <= '0;
            cmp_idx     <= '0;
            timeout_cnt <= '0;
            contour_acc <= '0;
            contour_out <= '0;
            tone_out    <= TONE_NONE;
            error_out   <= 1'b0;
        end else begin
            error_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        frame_idx   <= '0;
                        cmp_idx     <= '0;
                        timeout_cnt <= '0;
                        contour_acc <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (frame_take) begin
                        frame_idx   <= frame_idx + 1'b1;
                        timeout_cnt <= '0;
                    end else if (timeout_hit) begin
                        error_out <= 1'b1;
                    end else if (!capture_full) begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end
                ST_COMPARE: begin
                    contour_acc <= contour_next;
                    if (last_step) begin
                        contour_out <= contour_next;
                        tone_out    <= classify((2*MAX_STEPS)'(contour_next), STEPS);
                    end else begin
                        cmp_idx <= cmp_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tone_contour_classifier.sv
// Self-checking bench: a step/tone model derived from the percent rule,
// a per-cycle compare process, and directed frame sets with literal results.
module tb_tone_contour_classifier;

    localparam int NF = 4;
    localparam int DW = 32;
    localparam int TH = 20;
    localparam int TO = 50;
    localparam int CW = 2 * (NF - 1);

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          start_in = 1'b0;
    logic          frame_valid_in = 1'b0;
    logic [DW-1:0] frame_data_in = '0;
    logic          ready_out;
    logic          valid_out;
    logic [CW-1:0] contour_out;
    logic [2:0]    tone_out;
    logic          error_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int            cyc;
        logic [CW-1:0] contour;
        logic [2:0]    tone;
    } exp_t;

    exp_t          exp_q[$];
    int            err_q[$];
    logic [CW-1:0] held_contour = '0;
    logic [2:0]    held_tone = '0;

    tone_contour_classifier #(
        .DATA_WIDTH     (DW),
        .NUM_FRAMES     (NF),
        .THRESH_PCT     (TH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .start_in       (start_in),
        .frame_valid_in (frame_valid_in),
        .frame_data_in  (frame_data_in),
        .ready_out      (ready_out),
        .valid_out      (valid_out),
        .contour_out    (contour_out),
        .tone_out       (tone_out),
        .error_out      (error_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: grade steps by percent change of the earlier frame, then read the tone off the code sequence.
    function automatic void model(input int unsigned fr [NF], output logic [CW-1:0] c, output logic [2:0] t);
        longint d;
        longint mag;
        bit     rise, fall, fall_then_rise;
        c = '0;
        rise = 0;
        fall = 0;
        fall_then_rise = 0;
        for (int k = 1; k < NF; k++) begin
            d   = longint'(fr[k]) - longint'(fr[k-1]);
            mag = (d < 0) ? -d : d;
            if (d != 0 && mag * 100 >= longint'(TH) * longint'(fr[k-1])) begin
                if (d > 0) begin
                    c[2*k-2 +: 2] = 2'b01;
                    rise = 1;
                    if (fall) fall_then_rise = 1;
                end else begin
                    c[2*k-2 +: 2] = 2'b11;
                    fall = 1;
                end
            end
        end
        if (!rise && !fall)     t = 3'b001;
        else if (!fall)         t = 3'b010;
        else if (fall_then_rise) t = 3'b011;
        else if (!rise)         t = 3'b100;
        else                    t = 3'b000;
    endfunction

    // Per-cycle comparison against the scoreboard queues.
    always @(negedge clk_in) begin
        bit ev;
        bit ee;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) exp_q.delete(0);
        while (err_q.size() > 0 && err_q[0] < cyc) err_q.delete(0);
        ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        if (ev) begin
            held_contour = exp_q[0].contour;
            held_tone    = exp_q[0].tone;
            exp_q.delete(0);
        end
        ee = (err_q.size() > 0) && (err_q[0] == cyc);
        if (ee) err_q.delete(0);
        check("valid_out",   64'(valid_out),   64'(ev));
        check("error_out",   64'(error_out),   64'(ee));
        check("contour_out", 64'(contour_out), 64'(held_contour));
        check("tone_out",    64'(tone_out),    64'(held_tone));
    end

    task automatic wait_ready();
        for (int i = 0; i < 20 && !ready_out; i++) begin
            @(posedge clk_in);
            #1;
        end
        check("ready_wait", 64'(ready_out), 64'(1'b1));
    endtask

    task automatic send_frames(input int unsigned fr [NF], input int n);
        for (int i = 0; i < n; i++) begin
            frame_valid_in = 1'b1;
            frame_data_in  = fr[i];
            @(posedge clk_in);
            #1;
        end
        frame_valid_in = 1'b0;
    endtask

    task automatic do_start();
        start_in = 1'b1;
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
        check("ready_after_start", 64'(ready_out), 64'(1'b0));
    endtask

    // Full utterance; lit_c/lit_t are hand-computed and also pin the model.
    task automatic run(input int unsigned f0, input int unsigned f1, input int unsigned f2,
                       input int unsigned f3, input logic [CW-1:0] lit_c, input logic [2:0] lit_t,
                       input bit junk);
        int unsigned   fr [NF];
        logic [CW-1:0] mc;
        logic [2:0]    mt;
        exp_t          e;
        fr[0] = f0; fr[1] = f1; fr[2] = f2; fr[3] = f3;
        model(fr, mc, mt);
        check("model_contour", 64'(mc), 64'(lit_c));
        check("model_tone",    64'(mt), 64'(lit_t));
        wait_ready();
        if (junk) begin
            frame_valid_in = 1'b1;
            frame_data_in  = $urandom;
            @(posedge clk_in);
            #1;
            frame_valid_in = 1'b0;
        end
        do_start();
        send_frames(fr, NF);
        e.cyc = cyc + NF;
        e.contour = mc;
        e.tone = mt;
        exp_q.push_back(e);
        @(posedge clk_in);
        #1;
        repeat (NF) begin
            if (junk) begin
                frame_valid_in = 1'b1;
                frame_data_in  = $urandom;
            end
            @(posedge clk_in);
            #1;
        end
        frame_valid_in = 1'b0;
        check("held_contour", 64'(contour_out), 64'(lit_c));
        check("held_tone",    64'(tone_out),    64'(lit_t));
        check("ready_after_report", 64'(ready_out), 64'(1'b1));
    endtask

    initial begin
        int unsigned fr [NF];
        #1;
        check("rst_ready",   64'(ready_out),   64'(1'b1));
        check("rst_valid",   64'(valid_out),   64'(1'b0));
        check("rst_error",   64'(error_out),   64'(1'b0));
        check("rst_contour", 64'(contour_out), 64'(0));
        check("rst_tone",    64'(tone_out),    64'(0));
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        run(100, 100, 110, 105, 6'b00_00_00, 3'b001, 1'b1);
        run(100, 130, 170, 220, 6'b01_01_01, 3'b010, 1'b0);
        run(200, 150, 150, 190, 6'b01_00_11, 3'b011, 1'b1);
        run(300, 200, 120,  90, 6'b11_11_11, 3'b100, 1'b0);

        // Reset mid-COMPARE: outputs must drop before any further clock edge.
        fr[0] = 200; fr[1] = 150; fr[2] = 150; fr[3] = 190;
        wait_ready();
        do_start();
        send_frames(fr, NF);
        repeat (2) begin
            @(posedge clk_in);
            #1;
        end
        rst_in = 1'b1;
        exp_q.delete();
        held_contour = '0;
        held_tone    = '0;
        #1;
        check("midrst_ready",   64'(ready_out),   64'(1'b1));
        check("midrst_valid",   64'(valid_out),   64'(1'b0));
        check("midrst_error",   64'(error_out),   64'(1'b0));
        check("midrst_contour", 64'(contour_out), 64'(0));
        check("midrst_tone",    64'(tone_out),    64'(0));
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        // Frames with no start: nothing is captured, no result appears.
        send_frames(fr, NF);
        repeat (8) @(posedge clk_in);
        #1;
        check("nostart_ready", 64'(ready_out), 64'(1'b1));

        // Partial capture then reset: the next run must not see the old frames.
        fr[0] = 999; fr[1] = 1;
        do_start();
        send_frames(fr, 2);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        run(100, 130, 170, 220, 6'b01_01_01, 3'b010, 1'b0);

        run(100, 150, 100, 150, 6'b01_11_01, 3'b011, 1'b1);
        run(100, 120,  96,  96, 6'b00_11_01, 3'b000, 1'b0);
        run(  0,   0,  10,  10, 6'b00_01_00, 3'b010, 1'b0);
        run(100, 119, 143,   0, 6'b11_01_00, 3'b000, 1'b0);

        // Timeout: two frames then silence; one error strobe exactly TO cycles later.
        fr[0] = 100; fr[1] = 120;
        wait_ready();
        do_start();
        send_frames(fr, 2);
        err_q.push_back(cyc + TO);
        repeat (TO + 5) @(posedge clk_in);
        #1;
        check("timeout_ready", 64'(ready_out), 64'(1'b1));
        check("timeout_drained", 64'(err_q.size()), 64'(0));

        run(300, 200, 120, 90, 6'b11_11_11, 3'b100, 1'b0);

        @(negedge clk_in);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
